instruction_fetch: RTL

Sequential fetch unit on the requesting side of the 64-bit-address / 32-bit-data instruction memory port. It owns the program counter, drives `Address`, waits a fixed number of cycles for the memory read to settle, and captures `Data`. It then presents the word to decode over a valid/ready handshake. It supports taken-branch redirects (B, CBZ) and stops fetching at a fixed end-of-program address.

---
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch unit. It owns the PC, holds Address for RD_WAIT
// cycles, and captures Data. It offers the word to decode over valid/ready,
// redirects on taken branches, and parks in DONE at END_PC.
module instruction_fetch #(
    parameter int unsigned RD_WAIT  = 2,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] END_PC   = 64'h60
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] Address,
    input  logic [31:0] Data,
    output logic [31:0] InstrOut,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BranchTake,
    input  logic [63:0] BranchTarget,
    output logic        Done,
    output logic [15:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Counter value on the cycle whose closing edge samples Data.
    localparam logic [3:0] CNT_LAST = 4'(RD_WAIT - 1);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic [63:0] pc_plus4;
    logic [63:0] branch_pc;
    logic        accept;

    // The low target bits are architecturally ignored; redirects are word aligned.
    logic unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

    // Next-state logic: redirect overrides the wait/handshake sequencing, but a
    // word accepted in the same cycle as a redirect is still counted.
    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        valid_d       = valid_q;
        done_d        = done_q;
        fetch_count_d = fetch_count_q;

        pc_plus4  = pc_q + 64'd4;
        branch_pc = {BranchTarget[63:2], 2'b00};
        accept    = (state_q == ST_HOLD) && valid_q && InstrReady;

        if (accept) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        if (BranchTake) begin
            pc_d    = branch_pc;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
            if (branch_pc >= END_PC) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_WAIT;
                done_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        instr_d    = Data;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        valid_d = 1'b0;
                        pc_d    = pc_plus4;
                        cnt_d   = 4'd0;
                        if (pc_plus4 >= END_PC) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_WAIT;
            pc_q          <= RESET_PC;
            cnt_q         <= 4'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 64'd0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Address    = pc_q;
    assign InstrOut   = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign FetchCount = fetch_count_q;

endmodule
